pattern_sequencer: RTL and testbench
====================================

// Module: pattern_sequencer
// PURPOSE
//   Synthesisable exhaustive stimulus generator for combinational nets under test.
//   Steps through all 2^WIDTH input combinations and holds each for HOLD_CYCLES clocks.
//   Pulses a sample strobe so a downstream checker can capture the DUT response.
//   Supports four ordering modes, pause, stop and continuous repeat.
//   Sits between board switches/buttons and the net under test, on FPGA or in simulation.
// PARAMETERS
//   WIDTH        4   number of DUT inputs driven; legal 1..16
//   HOLD_CYCLES  10  clocks each combination is held; legal >= 1
// PORTS
//   clock      in   1      system clock, rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   start      in   1      begin a sequence (ignored while busy)
//   stop       in   1      abort the sequence and return to idle
//   pause      in   1      freeze the sequence while high
//   mode       in   2      00 binary up, 01 binary down, 10 Gray, 11 bit-reversed binary
//   repeat_en  in   1      1: wrap to the first pattern after the last one instead of finishing
//   pattern    out  WIDTH  stimulus driven into the DUT
//   index      out  WIDTH  ordinal of the current combination (0..2^WIDTH-1)
//   busy       out  1      sequence running (including while paused)
//   sample     out  1      one-cycle strobe on the last hold cycle of each pattern
//   wrap       out  1      one-cycle strobe when index wraps from 2^WIDTH-1 to 0
//   done       out  1      sequence completed; held until the next start
// BEHAVIOUR
//   Reset: state IDLE; pattern, index, busy, sample, wrap and done are all 0.
//   States: IDLE, RUN, DONE. PAUSE is not a separate state; it freezes RUN.
//   IDLE/DONE + start (and no stop): next cycle enters RUN.
//     - busy=1, done=0, index=0, pattern=map(0), hold counter=0.
//     - mode is latched at this point; mode changes mid-run are ignored.
//   RUN, pause=0: the hold counter increments each clock.
//     - At count HOLD_CYCLES-1: sample=1, the counter clears, and index advances.
//   RUN, pause=1: counter and index frozen, sample and wrap forced to 0.
//   Last index, last hold cycle:
//     - repeat_en=1: index wraps to 0 and wrap pulses for one cycle.
//     - repeat_en=0: enter DONE. busy=0, done=1, pattern/index hold their last values.
//   repeat_en is evaluated live, on the final hold cycle only.
//   stop (any state): next cycle IDLE, pattern=0, index=0, busy=0, done=0.
//     - stop beats start in the same cycle.
//   start while in RUN: ignored, no restart.
//   map(i): mode 00 -> i; 01 -> ~i; 10 -> i ^ (i>>1); 11 -> bit-reverse(i).
//   pattern and index are registered; both change on the same edge.
//   Run length without pause: 2^WIDTH * HOLD_CYCLES clocks from the RUN entry edge to done=1.
//   The hold counter is sized $clog2(HOLD_CYCLES+1).
//   HOLD_CYCLES=1: sample is high on every RUN cycle.
//   Asynchronous reset mid-run returns immediately to the reset state.
// STRUCTURE
//   Package pattern_seq_pkg:
//     - mode_t enum (MODE_BIN_UP, MODE_BIN_DOWN, MODE_GRAY, MODE_BITREV)
//     - state_t enum (IDLE, RUN, DONE)
//   Sub-module pattern_mapper #(WIDTH): combinational index + mode -> pattern.
//   Top level: FSM, hold counter, index counter, output registers.
// TESTING
//   1. WIDTH=4, HOLD=10, mode 00, pulse start -> pattern 0..15, each for 10 clocks;
//      16 sample pulses; done=1 exactly 160 clocks after RUN entry.
//   2. mode 10 -> pattern sequence 0,1,3,2,6,7,5,4,...,8; every step changes exactly one bit.
//   3. repeat_en=1 -> after pattern 15, index returns to 0; wrap pulses once per 160 clocks;
//      done stays 0.
//   4. pause high for 7 clocks at index 5 -> index/pattern frozen, no sample;
//      completes 7 clocks late (167).
//   5. stop at index 9 with start in the same cycle -> IDLE next cycle,
//      pattern=0, busy=0, done=0.
//   6. reset_n low mid-run (asynchronous, between edges) -> all outputs 0 at once;
//      a later start restarts from index 0.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types for the exhaustive pattern sequencer: ordering modes and FSM states.
package pattern_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BIN_UP   = 2'b00,
        MODE_BIN_DOWN = 2'b01,
        MODE_GRAY     = 2'b10,
        MODE_BITREV   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/pattern_sequencer_mapper.sv
// Combinational ordinal-to-stimulus mapping for the four supported ordering modes.
module pattern_mapper
    import pattern_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] index,
    input  mode_t            mode,
    output logic [WIDTH-1:0] pattern
);

    always_comb begin
        pattern = index;
        case (mode)
            MODE_BIN_UP:   pattern = index;
            MODE_BIN_DOWN: pattern = ~index;
            MODE_GRAY:     pattern = index ^ (index >> 1);
            MODE_BITREV: begin
                for (int b = 0; b < WIDTH; b++) begin
                    pattern[b] = index[WIDTH-1-b];
                end
            end
            default:       pattern = index;
        endcase
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Exhaustive stimulus generator: walks all 2^WIDTH combinations, holding each for
// HOLD_CYCLES clocks and strobing sample on the last hold cycle of every pattern.
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic             repeat_en,
    output logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] index,
    output logic             busy,
    output logic             sample,
    output logic             wrap,
    output logic             done
);

    localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0]  IDX_LAST = '1;

    state_t            state;
    mode_t             mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  idx_nxt;
    mode_t             mode_nxt;
    logic [WIDTH-1:0]  pat_nxt;
    logic              hold_last;
    logic              idx_last;

    // Outside RUN the next ordinal is the first one and the live mode is about to be latched.
    always_comb begin
        idx_nxt  = index + WIDTH'(1);
        mode_nxt = mode_q;
        if (state != RUN) begin
            idx_nxt  = '0;
            mode_nxt = mode_t'(mode);
        end
    end

    pattern_mapper #(
        .WIDTH(WIDTH)
    ) u_mapper (
        .index   (idx_nxt),
        .mode    (mode_nxt),
        .pattern (pat_nxt)
    );

    assign hold_last = (state == RUN) && !pause && (cnt == CNT_LAST);
    assign idx_last  = (index == IDX_LAST);

    // Strobes are decoded from registered state, gated by pause so a frozen run never strobes.
    assign sample = hold_last;
    assign wrap   = hold_last && idx_last && repeat_en;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mode_q  <= MODE_BIN_UP;
            cnt     <= '0;
            index   <= '0;
            pattern <= '0;
        end else if (stop) begin
            state   <= IDLE;
            cnt     <= '0;
            index   <= '0;
            pattern <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        mode_q  <= mode_t'(mode);
                        cnt     <= '0;
                        index   <= idx_nxt;
                        pattern <= pat_nxt;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (idx_last && !repeat_en) begin
                                state <= DONE;
                            end else begin
                                index   <= idx_nxt;
                                pattern <= pat_nxt;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: expected patterns queued at start, popped on sample.
module tb_pattern_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, stop, pause, repeat_en;
    logic [1:0] mode;
    logic [3:0] pattern, index;
    logic       busy, sample, wrap, done;
    logic [1:0] pattern1, index1;
    logic       busy1, sample1, wrap1, done1;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_wrap   = 0;
    int   n_samp   = 0;
    int   h1_cnt   = 0;
    logic done1_prev = 1'b0;
    bit   gray_chk = 0;
    bit   have_prev = 0;
    logic [3:0] prev_pat;

    int gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int rev_tab[16]  = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clock = ~clock;

    pattern_sequencer #(.WIDTH(4), .HOLD_CYCLES(10)) u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .repeat_en(repeat_en), .pattern(pattern), .index(index),
        .busy(busy), .sample(sample), .wrap(wrap), .done(done)
    );

    // Single-cycle hold instance runs alongside, never repeating.
    pattern_sequencer #(.WIDTH(2), .HOLD_CYCLES(1)) u_dut_h1 (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .repeat_en(1'b0), .pattern(pattern1), .index(index1),
        .busy(busy1), .sample(sample1), .wrap(wrap1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_pat(input logic [1:0] m, input int i);
        case (m)
            2'b00:   return 4'(i);
            2'b01:   return 4'(15 - i);
            2'b10:   return 4'(gray_tab[i]);
            default: return 4'(rev_tab[i]);
        endcase
    endfunction

    task automatic push_seq(input logic [1:0] m, input int first, input int last);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            e.pat = model_pat(m, i % 16);
            e.idx = 4'(i % 16);
            sb.push_back(e);
        end
    endtask

    always @(negedge clock) begin
        if (sample) begin
            n_samp++;
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pattern", pattern, e.pat);
                check("sb_index", index, e.idx);
            end
            if (gray_chk) begin
                if (have_prev) check("gray_onebit", $countones(pattern ^ prev_pat), 1);
                prev_pat  = pattern;
                have_prev = 1;
            end
        end
        if (wrap) begin
            n_wrap++;
            check("wrap_index", index, 15);
        end
        if (!reset_n) h1_cnt = 0;
        else if (busy1) begin
            h1_cnt++;
            check("h1_sample", sample1, !pause);
        end
        if (done1 && !done1_prev) begin
            check("h1_len", h1_cnt, 4);
            check("h1_last_idx", index1, 3);
            h1_cnt = 0;
        end
        done1_prev = done1;
    end

    task automatic run_seq(input logic [1:0] m, input int pause_idx, input int drop_rep_at,
                           input int exp_len);
        int cycles;
        bit paused;
        logic [3:0] fz_idx, fz_pat;
        paused = 0;
        mode   = m;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("entry_busy", busy, 1);
        check("entry_done", done, 0);
        check("entry_index", index, 0);
        check("entry_pattern", pattern, model_pat(m, 0));
        cycles = 0;
        while (!done && cycles < 1000) begin
            @(posedge clock); #1 cycles++;
            if (cycles == 30) mode = ~m;
            if (cycles == drop_rep_at) begin
                check("repeat_no_done", done, 0);
                repeat_en = 1'b0;
            end
            if (!paused && pause_idx >= 0 && int'(index) == pause_idx) begin
                paused = 1;
                pause  = 1'b1;
                fz_idx = index;
                fz_pat = pattern;
                repeat (7) begin
                    @(posedge clock); #1 cycles++;
                    check("pause_index", index, fz_idx);
                    check("pause_pattern", pattern, fz_pat);
                    check("pause_sample", sample, 0);
                end
                pause = 1'b0;
            end
        end
        check("run_len", cycles, exp_len);
        check("done_busy", busy, 0);
        check("done_hold_index", index, 15);
        check("done_hold_pattern", pattern, model_pat(m, 15));
        check("sb_leftover", sb.size(), 0);
    endtask

    initial begin
        int s0, w0, guard;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        repeat_en = 1'b0; mode = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pattern", pattern, 0);
        check("rst_index", index, 0);
        check("rst_busy", busy, 0);
        check("rst_sample", sample, 0);
        check("rst_wrap", wrap, 0);
        check("rst_done", done, 0);
        @(negedge clock) reset_n = 1'b1;

        // Binary up: 16 samples, done 160 clocks after entry.
        s0 = n_samp;
        push_seq(2'b00, 0, 15);
        run_seq(2'b00, -1, -1, 160);
        check("up_samples", n_samp - s0, 16);
        check("up_done", done, 1);

        // Gray ordering with single-bit steps.
        gray_chk = 1; have_prev = 0;
        push_seq(2'b10, 0, 15);
        run_seq(2'b10, -1, -1, 160);
        gray_chk = 0;

        push_seq(2'b01, 0, 15);
        run_seq(2'b01, -1, -1, 160);
        push_seq(2'b11, 0, 15);
        run_seq(2'b11, -1, -1, 160);

        // Repeat: one wrap, repeat dropped during the second lap.
        w0 = n_wrap;
        repeat_en = 1'b1;
        push_seq(2'b00, 0, 31);
        run_seq(2'b00, -1, 200, 320);
        check("repeat_wraps", n_wrap - w0, 1);

        // Pause for 7 clocks at index 5.
        push_seq(2'b00, 0, 15);
        run_seq(2'b00, 5, -1, 167);

        // Stop beats start at index 9.
        push_seq(2'b00, 0, 8);
        mode = 2'b00;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        guard = 0;
        while (index != 4'd9 && guard < 500) begin
            @(posedge clock); #1 guard++;
        end
        check("stop_reached_9", index, 9);
        stop = 1'b1; start = 1'b1;
        @(posedge clock); #1 stop = 1'b0; start = 1'b0;
        check("stop_pattern", pattern, 0);
        check("stop_index", index, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        repeat (3) @(posedge clock);
        #1 check("stop_stays_idle", busy, 0);
        check("stop_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-run, then a clean restart.
        push_seq(2'b00, 0, 15);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (52) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("arst_pattern", pattern, 0);
        check("arst_index", index, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sample", sample, 0);
        sb.delete();
        @(negedge clock) reset_n = 1'b1;
        push_seq(2'b00, 0, 15);
        run_seq(2'b00, -1, -1, 160);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
